store_commit_buffer: RTL and testbench
======================================

// Module: store_commit_buffer
// PURPOSE
//  Receiving end of the store reservation station's issue interface. Accepts
//  resolved stores (value, effective address, sub-type, ROB tag) into an
//  in-order FIFO and drains them one at a time to data memory over a req/ack
//  handshake. Reports each finished store to the ROB with a done pulse.
// PARAMETERS
//  DEPTH        4       FIFO entries (power of 2, >=2)
//  ROB_W        6       ROB tag width
//  INVALID_ROB  6'h10   tag driven on done_rob when no done is reported
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      asynchronous, active-high
//  st_valid     in   1      store offered this cycle
//  st_ready     out  1      buffer can accept (count < DEPTH)
//  st_data      in   32     store value (rs data1)
//  st_addr      in   32     effective byte address (base + offset)
//  st_subtype   in   3      000 SB, 001 SH, 010 SW; other codes invalid
//  st_rob       in   ROB_W  destination ROB tag
//  flush        in   1      mispredict flush
//  mem_req      out  1      memory write request
//  mem_addr     out  32     word address {addr[31:2],2'b00}
//  mem_wdata    out  32     lane-replicated write data
//  mem_be       out  4      byte enables
//  mem_ack      in   1      memory accepted the write (1-cycle pulse)
//  done_valid   out  1      1-cycle pulse: store retired
//  done_rob     out  ROB_W  tag of retired store, else INVALID_ROB
//  done_err     out  1      retired store faulted (0 unless macro enabled)
//  count        out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: FIFO empty, count=0, st_ready=1, mem_req=0, mem_addr/mem_wdata=0,
//   mem_be=0, done_valid=0, done_rob=INVALID_ROB, done_err=0, FSM=IDLE.
//   Reset mid-request drops mem_req immediately; no done is produced.
//  Push: st_valid & st_ready at edge -> entry written at tail. Push and pop
//   in the same cycle are allowed; push when full is ignored, nothing lost
//   upstream because st_ready=0.
//  FSM (all outputs registered):
//   IDLE: if count>0 -> load head into mem_* regs, mem_req=1, go REQ.
//         Invalid subtype -> no request, go DONE (done_err=0).
//   REQ:  hold mem_req/addr/data/be stable until mem_ack. On ack: mem_req=0,
//         pop head, go DONE.
//   DONE: done_valid=1 for exactly one cycle with head's tag, then IDLE.
//  Latency: a store pushed into an empty idle buffer at edge N gives mem_req=1
//   after edge N+1. With ack at edge M, done_valid is high for the cycle after
//   edge M. Minimum 3 cycles per store, strictly in order.
//  Lane rules, a=addr[1:0]:
//   SB: be=4'b0001<<a, wdata={4{data[7:0]}}
//   SH: be=a[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}
//   SW: be=4'b1111, wdata=data
//  flush: all entries not yet in REQ are discarded at the edge (count drops
//   to 0, or to 1 if REQ). An in-flight REQ is held until ack and then popped
//   without a done pulse. A push in the flush cycle is discarded.
//   A flush in DONE suppresses nothing: that pulse is already committed.
//  mem_ack outside REQ: ignored.
// CONFIGURATION
//  STORE_MISALIGN_CHECK_EN defined: SH with a[0]=1 or SW with a!=0 issues no
//   memory request; it goes straight to DONE with done_err=1.
//  Undefined: misaligned low address bits are ignored per the lane rules.
//   done_err is tied to 0.
// TESTING
//  SW data=32'hDEADBEEF addr=32'h104 tag=3, ack 2 cycles later -> mem_addr=
//   32'h104, be=1111, wdata=DEADBEEF; done_rob=3 one cycle after ack.
//  SB data=32'h000000A5 addr=32'h203 -> be=1000, wdata=32'hA5A5A5A5.
//   SH data=32'h1234 addr=32'h202 -> be=1100, wdata=32'h12341234.
//  Push 4 stores with ack held low -> count=4, st_ready=0. Fifth offer is
//   ignored. After 4 acks, done tags come out in push order.
//  Three queued stores, first in REQ, assert flush -> count=1. Ack completes
//   the write with no done_valid. Buffer then empty and IDLE.
//  Assert reset during REQ -> mem_req=0 and done_rob=INVALID_ROB immediately.
//   A later ack causes nothing.
//  With STORE_MISALIGN_CHECK_EN, SW addr=32'h102 tag=5 -> no mem_req;
//   done_valid with done_rob=5, done_err=1.

Source files
------------

// File: rtl/store_commit_buffer_if.sv
`default_nettype none
// =============================================================================
// Interface : store_commit_buffer_if
// Store issue, memory write and ROB completion signals of the store commit buffer.
// Revision  : 1.0
// =============================================================================
interface store_commit_buffer_if #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 6
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             st_valid;
    logic             st_ready;
    logic [31:0]      st_data;
    logic [31:0]      st_addr;
    logic [2:0]       st_subtype;
    logic [ROB_W-1:0] st_rob;
    logic             flush;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic             done_valid;
    logic [ROB_W-1:0] done_rob;
    logic             done_err;
    logic [CNT_W-1:0] count;

    modport slave (
        input  st_valid, st_data, st_addr, st_subtype, st_rob, flush, mem_ack,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               done_valid, done_rob, done_err, count
    );

    modport master (
        output st_valid, st_data, st_addr, st_subtype, st_rob, flush, mem_ack,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               done_valid, done_rob, done_err, count
    );
endinterface
`default_nettype wire

// File: rtl/store_commit_buffer.sv
`default_nettype none
// =============================================================================
// Module   : store_commit_buffer
// In-order store FIFO draining to data memory over req/ack, reporting each
// retired store to the ROB. Optional macro: STORE_MISALIGN_CHECK_EN.
// Revision : 1.0
// =============================================================================
module store_commit_buffer #(
    parameter int               DEPTH       = 4,
    parameter int               ROB_W       = 6,
    parameter logic [ROB_W-1:0] INVALID_ROB = 6'h10
) (
    input  wire logic            clock,
    input  wire logic            reset,
    store_commit_buffer_if.slave bus
);
    localparam int         PTR_W  = $clog2(DEPTH);
    localparam int         CNT_W  = PTR_W + 1;
    localparam logic [2:0] SUB_SB = 3'b000;
    localparam logic [2:0] SUB_SH = 3'b001;
    localparam logic [2:0] SUB_SW = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_addr [DEPTH];
    logic [2:0]       r_sub  [DEPTH];
    logic [ROB_W-1:0] r_rob  [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_kill;

    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [3:0]       r_mem_be;
    logic             r_done_valid;
    logic [ROB_W-1:0] r_done_rob;

    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_done_set;
    logic             w_reject;
    logic [31:0]      w_hd_data;
    logic [31:0]      w_hd_addr;
    logic [2:0]       w_hd_sub;
    logic [ROB_W-1:0] w_hd_rob;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [PTR_W-1:0] w_head_inc;

    assign w_hd_data  = r_data[r_head];
    assign w_hd_addr  = r_addr[r_head];
    assign w_hd_sub   = r_sub[r_head];
    assign w_hd_rob   = r_rob[r_head];
    assign w_head_inc = r_head + PTR_W'(1);

    assign bus.st_ready = (r_count < CNT_W'(DEPTH));
    assign w_push       = bus.st_valid & bus.st_ready & ~bus.flush;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_hd_data;
        case (w_hd_sub)
            SUB_SB: begin
                w_be    = 4'b0001 << w_hd_addr[1:0];
                w_wdata = {4{w_hd_data[7:0]}};
            end
            SUB_SH: begin
                w_be    = w_hd_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_hd_data[15:0]}};
            end
            SUB_SW:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

`ifdef STORE_MISALIGN_CHECK_EN
    logic w_misalign;
    logic w_err_set;
    logic r_done_err;

    assign w_misalign = ((w_hd_sub == SUB_SH) && w_hd_addr[0]) ||
                        ((w_hd_sub == SUB_SW) && (w_hd_addr[1:0] != 2'b00));
    assign w_reject   = (w_hd_sub > SUB_SW) || w_misalign;
    assign w_err_set  = w_done_set && (r_state == S_IDLE) && w_misalign;
`else
    assign w_reject   = (w_hd_sub > SUB_SW);
`endif

    // Rejected stores never touch memory: popped straight into the done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.flush && (r_count != '0)) begin
                    if (w_reject) begin
                        w_pop       = 1'b1;
                        w_done_set  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_ack) begin
                    w_pop = 1'b1;
                    if (r_kill || bus.flush) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_done_set  = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_tail] <= bus.st_data;
            r_addr[r_tail] <= bus.st_addr;
            r_sub[r_tail]  <= bus.st_subtype;
            r_rob[r_tail]  <= bus.st_rob;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_kill       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_done_valid <= 1'b0;
            r_done_rob   <= INVALID_ROB;
        end else begin
            r_state      <= w_state_nxt;
            r_done_valid <= w_done_set;
            r_done_rob   <= w_done_set ? w_hd_rob : INVALID_ROB;

            if (w_load) begin
                r_mem_req   <= 1'b1;
                r_mem_addr  <= {w_hd_addr[31:2], 2'b00};
                r_mem_wdata <= w_wdata;
                r_mem_be    <= w_be;
            end else if ((r_state == S_REQ) && bus.mem_ack) begin
                r_mem_req <= 1'b0;
            end

            // A flushed in-flight write still completes, but its done is dropped.
            r_kill <= (r_state == S_REQ) && !bus.mem_ack && (r_kill || bus.flush);

            if (bus.flush) begin
                if ((r_state == S_REQ) && !w_pop) begin
                    r_tail  <= w_head_inc;
                    r_count <= CNT_W'(1);
                end else begin
                    r_head  <= w_pop ? w_head_inc : r_head;
                    r_tail  <= w_pop ? w_head_inc : r_head;
                    r_count <= '0;
                end
            end else begin
                if (w_push) r_tail <= r_tail + PTR_W'(1);
                if (w_pop)  r_head <= w_head_inc;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

`ifdef STORE_MISALIGN_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_done_err <= 1'b0;
        else       r_done_err <= w_err_set;
    end
    assign bus.done_err = r_done_err;
`else
    assign bus.done_err = 1'b0;
`endif

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_be     = r_mem_be;
    assign bus.done_valid = r_done_valid;
    assign bus.done_rob   = r_done_rob;
    assign bus.count      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_store_commit_buffer.sv
`default_nettype none
// =============================================================================
// Module   : tb_store_commit_buffer
// Directed and randomized checks of store_commit_buffer against a queue model.
// Revision : 1.0
// =============================================================================
module tb_store_commit_buffer;
    localparam int               DEPTH = 4;
    localparam int               ROB_W = 6;
    localparam logic [ROB_W-1:0] INV   = 6'h10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    store_commit_buffer_if #(.DEPTH(DEPTH), .ROB_W(ROB_W)) bus ();

    store_commit_buffer #(
        .DEPTH      (DEPTH),
        .ROB_W      (ROB_W),
        .INVALID_ROB(INV)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0]      data;
        logic [31:0]      addr;
        logic [2:0]       sub;
        logic [ROB_W-1:0] rob;
    } st_t;

    st_t  mq[$];
    logic req_seen;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit mis(input st_t s);
        int a;
        a = int'(s.addr[1:0]);
        return ((s.sub == 3'd1) && (a % 2 == 1)) || ((s.sub == 3'd2) && (a != 0));
    endfunction

    function automatic bit rejected(input st_t s);
`ifdef STORE_MISALIGN_CHECK_EN
        return (s.sub > 3'd2) || mis(s);
`else
        return (s.sub > 3'd2);
`endif
    endfunction

    function automatic bit exp_err(input st_t s);
`ifdef STORE_MISALIGN_CHECK_EN
        return (s.sub <= 3'd2) && mis(s);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] exp_be(input st_t s);
        int a;
        a = int'(s.addr % 4);
        if (s.sub == 3'd0) return 4'(1 << a);
        if (s.sub == 3'd1) return (a >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input st_t s);
        if (s.sub == 3'd0) return 32'(s.data[7:0]) * 32'h01010101;
        if (s.sub == 3'd1) return 32'(s.data[15:0]) * 32'h00010001;
        return s.data;
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic offer(input logic [31:0] d, input logic [31:0] a,
                         input logic [2:0] s, input logic [ROB_W-1:0] r);
        bus.st_valid   = 1'b1;
        bus.st_data    = d;
        bus.st_addr    = a;
        bus.st_subtype = s;
        bus.st_rob     = r;
        tick();
        bus.st_valid   = 1'b0;
    endtask

    task automatic ack_one();
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    task automatic wait_req(input int bound);
        int n;
        n = 0;
        while ((bus.mem_req !== 1'b1) && (n < bound)) begin
            tick();
            n++;
        end
        chk("wait_req", bus.mem_req, 1);
    endtask

    task automatic rand_cycle(input bit allow_push);
        st_t s;
        bit  push_exp;
        bit  req_b;
        bit  ack_b;
        s.data = $urandom();
        s.addr = $urandom();
        s.sub  = 3'($urandom_range(0, 4));
        s.rob  = ROB_W'($urandom_range(0, 15));
        bus.st_valid   = allow_push && ($urandom_range(0, 2) != 0);
        bus.st_data    = s.data;
        bus.st_addr    = s.addr;
        bus.st_subtype = s.sub;
        bus.st_rob     = s.rob;
        req_b = (bus.mem_req === 1'b1);
        bus.mem_ack = req_b ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        ack_b = req_b && bus.mem_ack;
        chk("rnd_ready", bus.st_ready, mq.size() < DEPTH);
        push_exp = bus.st_valid && (mq.size() < DEPTH);
        tick();
        bus.mem_ack  = 1'b0;
        bus.st_valid = 1'b0;
        if (push_exp) mq.push_back(s);
        if (ack_b) chk("rnd_ack_done", bus.done_valid, 1);
        if (bus.done_valid === 1'b1) begin
            chk("rnd_done_q_nonempty", mq.size() > 0, 1);
            if (mq.size() > 0) begin
                chk("rnd_done_rob", bus.done_rob, mq[0].rob);
                chk("rnd_done_err", bus.done_err, exp_err(mq[0]));
                chk("rnd_issued", req_seen, !rejected(mq[0]));
                void'(mq.pop_front());
                req_seen = 1'b0;
            end
        end else begin
            chk("rnd_idle_rob", bus.done_rob, INV);
        end
        if (req_b && !ack_b) chk("rnd_req_hold", bus.mem_req, 1);
        if ((bus.mem_req === 1'b1) && !(req_b && !ack_b)) begin
            chk("rnd_req_q_nonempty", mq.size() > 0, 1);
            if (mq.size() > 0) begin
                chk("rnd_req_allowed", rejected(mq[0]), 0);
                chk("rnd_addr", bus.mem_addr, mq[0].addr & ~32'd3);
                chk("rnd_be", bus.mem_be, exp_be(mq[0]));
                chk("rnd_wdata", bus.mem_wdata, exp_wd(mq[0]));
                req_seen = 1'b1;
            end
        end
        chk("rnd_count", bus.count, mq.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.st_valid   = 1'b0;
        bus.st_data    = '0;
        bus.st_addr    = '0;
        bus.st_subtype = '0;
        bus.st_rob     = '0;
        bus.flush      = 1'b0;
        bus.mem_ack    = 1'b0;
        req_seen       = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        chk("rst_ready", bus.st_ready, 1);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_done_v", bus.done_valid, 0);
        chk("rst_done_rob", bus.done_rob, 6'h10);
        chk("rst_done_err", bus.done_err, 0);
        chk("rst_count", bus.count, 0);
        tick();

        // Word store, ack two cycles after the request appears
        offer(32'hDEADBEEF, 32'h104, 3'b010, 6'd3);
        chk("sw_count", bus.count, 1);
        chk("sw_req_lat", bus.mem_req, 0);
        tick();
        chk("sw_req", bus.mem_req, 1);
        chk("sw_addr", bus.mem_addr, 32'h104);
        chk("sw_be", bus.mem_be, 4'b1111);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        chk("sw_hold", bus.mem_req, 1);
        ack_one();
        chk("sw_req_drop", bus.mem_req, 0);
        chk("sw_done_v", bus.done_valid, 1);
        chk("sw_done_rob", bus.done_rob, 3);
        chk("sw_done_err", bus.done_err, 0);
        chk("sw_count0", bus.count, 0);
        tick();
        chk("sw_done_pulse", bus.done_valid, 0);
        chk("sw_done_inv", bus.done_rob, 6'h10);

        offer(32'h000000A5, 32'h203, 3'b000, 6'd4);
        tick();
        chk("sb_addr", bus.mem_addr, 32'h200);
        chk("sb_be", bus.mem_be, 4'b1000);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5A5A5);
        ack_one();
        chk("sb_done_rob", bus.done_rob, 4);
        tick();

        offer(32'h00001234, 32'h202, 3'b001, 6'd5);
        tick();
        chk("sh_be", bus.mem_be, 4'b1100);
        chk("sh_wdata", bus.mem_wdata, 32'h12341234);
        ack_one();
        chk("sh_done_rob", bus.done_rob, 5);
        tick();

        // Fill the FIFO with ack held low
        for (int i = 0; i < 4; i++)
            offer(32'h1000 + i, 32'h300 + 4 * i, 3'b010, ROB_W'(20 + i));
        chk("full_count", bus.count, 4);
        chk("full_ready", bus.st_ready, 0);
        offer(32'hBAD, 32'h400, 3'b010, 6'd9);
        chk("full_ignored", bus.count, 4);
        for (int i = 0; i < 4; i++) begin
            wait_req(10);
            chk("full_addr", bus.mem_addr, 32'h300 + 4 * i);
            ack_one();
            chk("full_done_v", bus.done_valid, 1);
            chk("full_order", bus.done_rob, 20 + i);
        end
        tick();
        chk("full_drained", bus.count, 0);

        // Flush with the head in flight and a push in the flush cycle
        offer(32'h11, 32'h500, 3'b010, 6'd30);
        offer(32'h22, 32'h504, 3'b010, 6'd31);
        offer(32'h33, 32'h508, 3'b010, 6'd32);
        chk("fl_count3", bus.count, 3);
        chk("fl_inreq", bus.mem_req, 1);
        bus.flush    = 1'b1;
        bus.st_valid = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.st_valid = 1'b0;
        chk("fl_count1", bus.count, 1);
        chk("fl_req_held", bus.mem_req, 1);
        ack_one();
        chk("fl_req_drop", bus.mem_req, 0);
        chk("fl_no_done", bus.done_valid, 0);
        chk("fl_count0", bus.count, 0);
        tick();
        chk("fl_no_done2", bus.done_valid, 0);
        chk("fl_idle", bus.mem_req, 0);

        // Asynchronous reset in the middle of a request
        offer(32'h77, 32'h600, 3'b010, 6'd40);
        tick();
        chk("ar_inreq", bus.mem_req, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", bus.mem_req, 0);
        chk("ar_rob", bus.done_rob, 6'h10);
        chk("ar_count", bus.count, 0);
        @(negedge clock);
        reset = 1'b0;
        ack_one();
        chk("ar_no_done", bus.done_valid, 0);
        chk("ar_no_req", bus.mem_req, 0);
        tick();
        chk("ar_no_done2", bus.done_valid, 0);

        // Invalid sub-type retires without a memory request
        offer(32'h88, 32'h700, 3'b011, 6'd7);
        chk("inv_count", bus.count, 1);
        tick();
        chk("inv_done_v", bus.done_valid, 1);
        chk("inv_done_rob", bus.done_rob, 7);
        chk("inv_done_err", bus.done_err, 0);
        chk("inv_no_req", bus.mem_req, 0);
        chk("inv_count0", bus.count, 0);
        tick();

        // Misaligned word store
        offer(32'h55, 32'h102, 3'b010, 6'd5);
        tick();
`ifdef STORE_MISALIGN_CHECK_EN
        chk("mis_no_req", bus.mem_req, 0);
        chk("mis_done_v", bus.done_valid, 1);
        chk("mis_done_rob", bus.done_rob, 5);
        chk("mis_done_err", bus.done_err, 1);
`else
        chk("mis_req", bus.mem_req, 1);
        chk("mis_addr", bus.mem_addr, 32'h100);
        chk("mis_be", bus.mem_be, 4'b1111);
        ack_one();
        chk("mis_done_rob", bus.done_rob, 5);
        chk("mis_done_err", bus.done_err, 0);
`endif
        tick();
        tick();

        req_seen = 1'b0;
        for (int c = 0; c < 2000; c++) rand_cycle(1'b1);
        for (int c = 0; (c < 300) && (mq.size() > 0); c++) rand_cycle(1'b0);
        chk("drain_empty", mq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
